key_press_conditioner: RTL and testbench

KEY_PRESS_CONDITIONER -- requirements
Module: key_press_conditioner

---
 rtl/key_press_conditioner_if.sv | 21 ++
 rtl/key_press_conditioner.sv | 85 ++++++++
 tb/tb_key_press_conditioner.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/key_press_conditioner_if.sv
// Pushbutton conditioner signal bundle: raw active-low keys and arm in,
// debounced levels, press pulses and press statistics out.
interface key_press_conditioner_if;
  logic [3:0] KEY;
  logic       arm;
  logic [3:0] key_down;
  logic [3:0] key_press;
  logic       go;
  logic       multi;
  logic [7:0] press_total;

  modport slave (
    input  KEY, arm,
    output key_down, key_press, go, multi, press_total
  );

  modport master (
    output KEY, arm,
    input  key_down, key_press, go, multi, press_total
  );
endinterface

// File: rtl/key_press_conditioner.sv
// Synchronizes and debounces four active-low pushbuttons, emitting aligned
// per-key press pulses, a combined go/multi pulse and a wrapping press count.
module key_press_conditioner #(
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter int unsigned CNT_W           = 20
) (
  input  logic                    clk,
  input  logic                    reset,
  key_press_conditioner_if.slave  bus
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [3:0]       sync1_q, sync1_d;
  logic [3:0]       sync2_q, sync2_d;
  logic [3:0]       deb_q, deb_d;
  logic [CNT_W-1:0] cnt_q [4];
  logic [CNT_W-1:0] cnt_d [4];
  logic [3:0]       key_press_q, key_press_d;
  logic             go_q, go_d;
  logic             multi_q, multi_d;
  logic [7:0]       press_total_q, press_total_d;
  logic [2:0]       press_cnt;

  always_comb begin
    sync1_d     = ~bus.KEY;
    sync2_d     = sync1_q;
    deb_d       = deb_q;
    key_press_d = '0;
    for (int unsigned i = 0; i < 4; i++) begin
      cnt_d[i] = cnt_q[i];
      if (sync2_q[i] == deb_q[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] == CNT_LAST) begin
        deb_d[i]       = sync2_q[i];
        cnt_d[i]       = '0;
        // Only a 0->1 acceptance while armed is reported; disarmed presses are dropped.
        key_press_d[i] = sync2_q[i] & bus.arm;
      end else begin
        cnt_d[i] = cnt_q[i] + CNT_W'(1);
      end
    end

    press_cnt = '0;
    for (int unsigned i = 0; i < 4; i++) begin
      press_cnt = press_cnt + 3'(key_press_d[i]);
    end
    go_d          = |key_press_d;
    multi_d       = (press_cnt >= 3'd2);
    press_total_d = press_total_q + (go_d ? 8'd1 : 8'd0);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q       <= '0;
      sync2_q       <= '0;
      deb_q         <= '0;
      for (int unsigned i = 0; i < 4; i++) begin
        cnt_q[i] <= '0;
      end
      key_press_q   <= '0;
      go_q          <= 1'b0;
      multi_q       <= 1'b0;
      press_total_q <= '0;
    end else begin
      sync1_q       <= sync1_d;
      sync2_q       <= sync2_d;
      deb_q         <= deb_d;
      for (int unsigned i = 0; i < 4; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
      key_press_q   <= key_press_d;
      go_q          <= go_d;
      multi_q       <= multi_d;
      press_total_q <= press_total_d;
    end
  end

  assign bus.key_down    = deb_q;
  assign bus.key_press   = key_press_q;
  assign bus.go          = go_q;
  assign bus.multi       = multi_q;
  assign bus.press_total = press_total_q;

endmodule

// File: tb/tb_key_press_conditioner.sv
// Directed bench for key_press_conditioner with DEBOUNCE_CYCLES = 4.
module tb_key_press_conditioner;

  logic clk;
  logic reset;
  int   total_cnt;
  int   bad_cnt;

  key_press_conditioner_if bus ();

  key_press_conditioner #(
    .DEBOUNCE_CYCLES (4),
    .CNT_W           (4)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [3:0] key;
    logic       arm;
    int         n;
    logic [3:0] down;
    logic [3:0] press;
    logic       go;
    logic       multi;
    logic [7:0] tot;
  } vec_t;

  vec_t vt[$];

  task automatic check(input string name, input logic [7:0] got, input logic [7:0] exp);
    total_cnt++;
    if (got !== exp) begin
      bad_cnt++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all(input string tag, input logic [3:0] down, input logic [3:0] press,
                           input logic go, input logic multi, input logic [7:0] tot);
    check({tag, ".key_down"},    8'(bus.key_down),  8'(down));
    check({tag, ".key_press"},   8'(bus.key_press), 8'(press));
    check({tag, ".go"},          8'(bus.go),        8'(go));
    check({tag, ".multi"},       8'(bus.multi),     8'(multi));
    check({tag, ".press_total"}, bus.press_total,   tot);
  endtask

  task automatic do_reset();
    reset   = 1'b1;
    bus.KEY = 4'hF;
    tick();
    tick();
    reset = 1'b0;
  endtask

  initial begin
    total_cnt = 0;
    bad_cnt   = 0;
    reset     = 1'b1;
    bus.KEY   = 4'hF;
    bus.arm   = 1'b1;
    tick();
    tick();
    check_all("reset_state", 4'h0, 4'h0, 1'b0, 1'b0, 8'd0);
    reset = 1'b0;

    // clean press on KEY[1], release 6 edges later
    vt.push_back('{4'b1101, 1'b1, 5, 4'b0000, 4'b0000, 1'b0, 1'b0, 8'd0});
    vt.push_back('{4'b1101, 1'b1, 1, 4'b0010, 4'b0010, 1'b1, 1'b0, 8'd1});
    vt.push_back('{4'b1101, 1'b1, 1, 4'b0010, 4'b0000, 1'b0, 1'b0, 8'd1});
    vt.push_back('{4'b1111, 1'b1, 5, 4'b0010, 4'b0000, 1'b0, 1'b0, 8'd1});
    vt.push_back('{4'b1111, 1'b1, 3, 4'b0000, 4'b0000, 1'b0, 1'b0, 8'd1});
    // bounce on KEY[2]: 3 low, 1 high, then held low
    vt.push_back('{4'b1011, 1'b1, 3, 4'b0000, 4'b0000, 1'b0, 1'b0, 8'd1});
    vt.push_back('{4'b1111, 1'b1, 1, 4'b0000, 4'b0000, 1'b0, 1'b0, 8'd1});
    vt.push_back('{4'b1011, 1'b1, 5, 4'b0000, 4'b0000, 1'b0, 1'b0, 8'd1});
    vt.push_back('{4'b1011, 1'b1, 1, 4'b0100, 4'b0100, 1'b1, 1'b0, 8'd2});
    vt.push_back('{4'b1011, 1'b1, 2, 4'b0100, 4'b0000, 1'b0, 1'b0, 8'd2});
    vt.push_back('{4'b1111, 1'b1, 5, 4'b0100, 4'b0000, 1'b0, 1'b0, 8'd2});
    vt.push_back('{4'b1111, 1'b1, 3, 4'b0000, 4'b0000, 1'b0, 1'b0, 8'd2});
    // simultaneous KEY[0] and KEY[2]
    vt.push_back('{4'b1010, 1'b1, 5, 4'b0000, 4'b0000, 1'b0, 1'b0, 8'd2});
    vt.push_back('{4'b1010, 1'b1, 1, 4'b0101, 4'b0101, 1'b1, 1'b1, 8'd3});
    vt.push_back('{4'b1010, 1'b1, 1, 4'b0101, 4'b0000, 1'b0, 1'b0, 8'd3});
    vt.push_back('{4'b1111, 1'b1, 5, 4'b0101, 4'b0000, 1'b0, 1'b0, 8'd3});
    vt.push_back('{4'b1111, 1'b1, 3, 4'b0000, 4'b0000, 1'b0, 1'b0, 8'd3});
    // disarmed press on KEY[3], then arm raised while held
    vt.push_back('{4'b0111, 1'b0, 5, 4'b0000, 4'b0000, 1'b0, 1'b0, 8'd3});
    vt.push_back('{4'b0111, 1'b0, 1, 4'b1000, 4'b0000, 1'b0, 1'b0, 8'd3});
    vt.push_back('{4'b0111, 1'b1, 4, 4'b1000, 4'b0000, 1'b0, 1'b0, 8'd3});
    vt.push_back('{4'b1111, 1'b1, 5, 4'b1000, 4'b0000, 1'b0, 1'b0, 8'd3});
    vt.push_back('{4'b1111, 1'b1, 3, 4'b0000, 4'b0000, 1'b0, 1'b0, 8'd3});

    foreach (vt[k]) begin
      for (int r = 0; r < vt[k].n; r++) begin
        bus.KEY = vt[k].key;
        bus.arm = vt[k].arm;
        tick();
        check_all($sformatf("vec%0d.%0d", k, r), vt[k].down, vt[k].press,
                  vt[k].go, vt[k].multi, vt[k].tot);
      end
    end

    // 256 armed presses wrap press_total back to 0
    bus.arm = 1'b1;
    do_reset();
    for (int p = 0; p < 256; p++) begin
      bus.KEY = 4'b1110;
      for (int c = 0; c < 5; c++) tick();
      tick();
      check($sformatf("wrap_go%0d", p), 8'(bus.go), 8'd1);
      check($sformatf("wrap_total%0d", p), bus.press_total, 8'(p + 1));
      bus.KEY = 4'b1111;
      for (int c = 0; c < 8; c++) tick();
    end
    check_all("wrap_end", 4'h0, 4'h0, 1'b0, 1'b0, 8'd0);

    // reset asserted mid-count while another key is held and total is nonzero
    bus.KEY = 4'b1110;
    for (int c = 0; c < 7; c++) tick();
    check_all("pre_rst", 4'b0001, 4'h0, 1'b0, 1'b0, 8'd1);
    bus.KEY = 4'b1100;
    for (int c = 0; c < 4; c++) tick();
    #3;
    reset = 1'b1;
    #1;
    check_all("rst_midcount_async", 4'h0, 4'h0, 1'b0, 1'b0, 8'd0);
    tick();
    tick();
    reset   = 1'b0;
    bus.KEY = 4'b1101;
    for (int e = 1; e <= 5; e++) begin
      tick();
      check_all($sformatf("post_rst_e%0d", e), 4'h0, 4'h0, 1'b0, 1'b0, 8'd0);
    end
    tick();
    check_all("post_rst_e6", 4'b0010, 4'b0010, 1'b1, 1'b0, 8'd1);

    // reset asserted during a pulse clears it at once; no late pulse
    bus.KEY = 4'b1111;
    for (int c = 0; c < 8; c++) tick();
    bus.KEY = 4'b1011;
    for (int c = 0; c < 6; c++) tick();
    check_all("pulse_before_rst", 4'b0100, 4'b0100, 1'b1, 1'b0, 8'd2);
    #2;
    reset = 1'b1;
    #1;
    check_all("rst_midpulse_async", 4'h0, 4'h0, 1'b0, 1'b0, 8'd0);
    tick();
    reset   = 1'b0;
    bus.KEY = 4'b1111;
    for (int c = 0; c < 8; c++) begin
      tick();
      check_all($sformatf("after_pulse_rst%0d", c), 4'h0, 4'h0, 1'b0, 1'b0, 8'd0);
    end

    $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
    $finish;
  end

endmodule
